// File: rtl/vector_reader.sv
// Reads up to MAX_NODES consecutive memory words starting at a byte address and
// captures the low VALUE_WIDTH bits of each into data_vector, then raises ready.
module vector_reader #(
  parameter int unsigned MAX_NODES   = 8,
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned MADDR_WIDTH = 16,
  parameter int unsigned MDATA_WIDTH = 32
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    enable,
  input  logic [MADDR_WIDTH-1:0]                  starting_address,
  input  logic [INDEX_WIDTH-1:0]                  number_of_nodes,
  output logic                                    mem_read_enable,
  output logic [MADDR_WIDTH-1:0]                  mem_addr,
  input  logic                                    wait_request,
  input  logic [MDATA_WIDTH-1:0]                  mem_read_data,
  input  logic                                    mem_read_valid,
  output logic [MAX_NODES-1:0][VALUE_WIDTH-1:0]   data_vector,
  output logic                                    ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DONE} state_t;

  localparam logic [MADDR_WIDTH-1:0] WORD_BYTES = MADDR_WIDTH'(MDATA_WIDTH / 8);
  localparam logic [INDEX_WIDTH-1:0] MAX_COUNT  = INDEX_WIDTH'(MAX_NODES);

  state_t                  state_q, state_d;
  logic [MADDR_WIDTH-1:0]  start_q;
  logic [INDEX_WIDTH-1:0]  count_q;
  logic [INDEX_WIDTH-1:0]  index_q;
  logic                    armed_q;
  logic                    capture;
  logic                    start_latch;
  logic                    start_go;
  logic                    unused_data;

  // Only the low VALUE_WIDTH bits of each word are kept.
  assign unused_data = ^mem_read_data;

  // IDLE spends one cycle latching the pass parameters (armed_q) before acting on them.
  assign start_latch = (state_q == IDLE) && enable && !armed_q;
  assign start_go    = (state_q == IDLE) && enable && armed_q;

  assign mem_addr = start_q + MADDR_WIDTH'(index_q) * WORD_BYTES;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    capture         = 1'b0;
    mem_read_enable = 1'b0;
    ready           = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_go) state_d = (count_q == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        mem_read_enable = 1'b1;
        if (!wait_request) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (mem_read_valid) begin
          capture = enable;
          state_d = (index_q + INDEX_WIDTH'(1) == count_q) ? DONE : ISSUE;
        end
      end
      DONE: ready = 1'b1;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_q     <= '0;
      count_q     <= '0;
      index_q     <= '0;
      armed_q     <= 1'b0;
      data_vector <= '0;
    end else begin
      armed_q <= start_latch;
      if (start_latch) begin
        start_q <= starting_address;
        count_q <= (number_of_nodes > MAX_COUNT) ? MAX_COUNT : number_of_nodes;
      end
      if (start_go) index_q <= '0;
      if (capture) begin
        for (int unsigned i = 0; i < MAX_NODES; i++) begin
          if (index_q == INDEX_WIDTH'(i)) data_vector[i] <= mem_read_data[VALUE_WIDTH-1:0];
        end
        index_q <= index_q + INDEX_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_vector_reader.sv
// Bench for vector_reader: a randomized memory responder plus an array model of the
// expected vector contents, address sequence and handshake timing.
module tb_vector_reader;

  localparam int MAXN = 8;

  logic                      clk;
  logic                      reset;
  logic                      enable;
  logic [15:0]               starting_address;
  logic [7:0]                number_of_nodes;
  logic                      mem_read_enable;
  logic [15:0]               mem_addr;
  logic                      wait_request;
  logic [31:0]               mem_read_data;
  logic                      mem_read_valid;
  logic [MAXN-1:0][15:0]     data_vector;
  logic                      ready;

  vector_reader #(
    .MAX_NODES  (MAXN),
    .INDEX_WIDTH(8),
    .VALUE_WIDTH(16),
    .MADDR_WIDTH(16),
    .MDATA_WIDTH(32)
  ) dut (
    .clock           (clk),
    .reset           (reset),
    .enable          (enable),
    .starting_address(starting_address),
    .number_of_nodes (number_of_nodes),
    .mem_read_enable (mem_read_enable),
    .mem_addr        (mem_addr),
    .wait_request    (wait_request),
    .mem_read_data   (mem_read_data),
    .mem_read_valid  (mem_read_valid),
    .data_vector     (data_vector),
    .ready           (ready)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  // shared between the stimulus and the responder
  logic [31:0] mem_seed = 32'h1234_5678;
  bit          dir_data = 0;
  bit          cfg_junk = 0;
  int          cfg_stall_pct = 0;
  int          cfg_lat = 0;
  int          stall_left = 0;
  logic [15:0] exp_start = '0;
  int          pass_k = 0;
  int          req_cycles = 0;
  int          last_valid_cyc = 0;
  int          ready_cyc = 0;
  int          en_cyc = 0;
  logic [15:0] exp_vec [MAXN];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [15:0] a);
    if (dir_data) return 32'hA + 32'((a - 16'h0100) >> 2);
    return ({16'h0, a} * 32'h9E37_79B1) ^ mem_seed;
  endfunction

  // Memory responder: stalls, returns data cfg_lat+1 cycles after acceptance,
  // checks the request address sequence, request stability and single outstanding read.
  initial begin
    int          pend;
    int          pb;
    bit          prev_stall;
    logic [15:0] prev_addr;
    logic [15:0] resp_addr;
    pend = 0; prev_stall = 0; prev_addr = '0; resp_addr = '0;
    wait_request = 0; mem_read_valid = 0; mem_read_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0; prev_stall = 0;
        mem_read_valid = 0; wait_request = 0;
      end else begin
        if (prev_stall && enable) begin
          chk("stall_ren", {31'b0, mem_read_enable}, 1);
          chk("stall_addr", {16'h0, mem_addr}, {16'h0, prev_addr});
        end
        if (mem_read_enable) req_cycles++;
        pb = pend;
        mem_read_valid = 0;
        mem_read_data  = $urandom;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            mem_read_valid = 1;
            mem_read_data  = word(resp_addr);
            last_valid_cyc = cyc;
          end
        end else if (cfg_junk && $urandom_range(3) == 0) begin
          mem_read_valid = 1;
        end
        if (mem_read_enable && stall_left > 0 && pass_k == 1) begin
          wait_request = 1;
          stall_left--;
        end else begin
          wait_request = ($urandom_range(99) < cfg_stall_pct);
        end
        if (mem_read_enable && !wait_request) begin
          chk("one_outstanding", pb, 0);
          chk("addr", {16'h0, mem_addr}, {16'h0, exp_start + 16'(pass_k * 4)});
          pass_k++;
          resp_addr = mem_addr;
          pend = cfg_lat + 1;
        end
        prev_stall = mem_read_enable && wait_request;
        prev_addr  = mem_addr;
      end
    end
  end

  task automatic run_pass(input logic [15:0] st, input logic [7:0] n,
                          input int spct, input int lat, input bit junk);
    int          cnt;
    bit          seen;
    logic [31:0] w;
    @(negedge clk);
    cfg_stall_pct = spct; cfg_lat = lat; cfg_junk = junk;
    exp_start = st; pass_k = 0; req_cycles = 0;
    mem_seed = $urandom;
    cnt = (int'(n) > MAXN) ? MAXN : int'(n);
    starting_address = st; number_of_nodes = n; enable = 1;
    en_cyc = cyc;
    seen = 0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      if (t == 2) begin
        starting_address = 16'($urandom);
        number_of_nodes  = 8'($urandom);
      end
      if (ready) begin
        seen = 1;
        break;
      end
    end
    ready_cyc = cyc;
    chk("ready_seen", {31'b0, seen}, 1);
    for (int i = 0; i < cnt; i++) begin
      w = word(st + 16'(i * 4));
      exp_vec[i] = w[15:0];
    end
    chk("read_count", pass_k, cnt);
    for (int i = 0; i < MAXN; i++) chk("data", {16'h0, data_vector[i[2:0]]}, {16'h0, exp_vec[i]});
    @(posedge clk); #1;
    chk("ready_hold", {31'b0, ready}, 1);
    chk("ren_done", {31'b0, mem_read_enable}, 0);
    @(negedge clk);
    enable = 0;
    @(posedge clk); #1;
    chk("ready_clear", {31'b0, ready}, 0);
  endtask

  initial begin
    bit got;
    reset = 1; enable = 0; starting_address = '0; number_of_nodes = '0;
    for (int i = 0; i < MAXN; i++) exp_vec[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_ren", {31'b0, mem_read_enable}, 0);
    chk("rst_addr", {16'h0, mem_addr}, 0);
    for (int i = 0; i < MAXN; i++) chk("rst_data", {16'h0, data_vector[i[2:0]]}, 0);
    @(negedge clk);
    reset = 0;

    // three elements, zero wait, data A/B/C
    dir_data = 1;
    run_pass(16'h0100, 8'd3, 0, 0, 0);
    chk("ready_latency", ready_cyc - last_valid_cyc, 1);
    chk("dv0", {16'h0, data_vector[0]}, 32'hA);
    chk("dv1", {16'h0, data_vector[1]}, 32'hB);
    chk("dv2", {16'h0, data_vector[2]}, 32'hC);
    chk("dv3_untouched", {16'h0, data_vector[3]}, 0);
    dir_data = 0;

    // element 1 stalled for four cycles
    stall_left = 4;
    run_pass(16'h0200, 8'd3, 0, 0, 0);
    chk("stall_applied", stall_left, 0);

    // empty pass
    run_pass(16'h0300, 8'd0, 0, 0, 1);
    chk("n0_latency", ready_cyc - en_cyc, 2);
    chk("n0_no_request", req_cycles, 0);

    // count clamps to MAX_NODES; address wraps
    run_pass(16'hFFF0, 8'(MAXN + 5), 20, 1, 1);
    run_pass(16'h0400, 8'd2, 0, 2, 1);

    for (int p = 0; p < 8; p++)
      run_pass(16'($urandom), 8'($urandom_range(12)), $urandom_range(50),
               $urandom_range(3), 1'($urandom_range(1)));

    // abort while a read is outstanding; its late response must be dropped
    @(negedge clk);
    cfg_stall_pct = 0; cfg_lat = 3; cfg_junk = 0;
    exp_start = 16'h0500; pass_k = 0; mem_seed = $urandom;
    starting_address = 16'h0500; number_of_nodes = 8'd5; enable = 1;
    got = 0;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk); #1;
      if (pass_k >= 1) begin
        got = 1;
        break;
      end
    end
    chk("abort_accept_seen", {31'b0, got}, 1);
    enable = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_ready", {31'b0, ready}, 0);
    chk("abort_ren", {31'b0, mem_read_enable}, 0);
    for (int i = 0; i < MAXN; i++) chk("abort_data", {16'h0, data_vector[i[2:0]]}, {16'h0, exp_vec[i]});
    run_pass(16'h0500, 8'd5, 10, 0, 1);

    // reset in the middle of a pass
    @(negedge clk);
    cfg_stall_pct = 0; cfg_lat = 1; cfg_junk = 0;
    exp_start = 16'h0600; pass_k = 0;
    starting_address = 16'h0600; number_of_nodes = 8'd8; enable = 1;
    repeat (6) @(posedge clk);
    #1;
    reset = 1; enable = 0;
    @(posedge clk); #1;
    chk("midrst_ready", {31'b0, ready}, 0);
    chk("midrst_ren", {31'b0, mem_read_enable}, 0);
    chk("midrst_addr", {16'h0, mem_addr}, 0);
    for (int i = 0; i < MAXN; i++) begin
      exp_vec[i] = '0;
      chk("midrst_data", {16'h0, data_vector[i[2:0]]}, 0);
    end
    @(negedge clk);
    reset = 0;
    repeat (2) @(posedge clk);
    run_pass(16'($urandom), 8'd4, 30, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
